// File: rtl/stream_demux_1to4_if.sv
// Stream bus for stream_demux_1to4: one input stream with route select, four output channels.
// master drives the input stream and the channel readies; slave is the demultiplexer.
interface stream_demux_1to4_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         S0;
   logic         S1;
   logic         y0_valid, y1_valid, y2_valid, y3_valid;
   logic         y0_ready, y1_ready, y2_ready, y3_ready;
   logic [W-1:0] y0, y1, y2, y3;

   modport master (
      output in_valid, in_data, S0, S1,
      output y0_ready, y1_ready, y2_ready, y3_ready,
      input  in_ready,
      input  y0_valid, y1_valid, y2_valid, y3_valid,
      input  y0, y1, y2, y3
   );

   modport slave (
      input  in_valid, in_data, S0, S1,
      input  y0_ready, y1_ready, y2_ready, y3_ready,
      output in_ready,
      output y0_valid, y1_valid, y2_valid, y3_valid,
      output y0, y1, y2, y3
   );
endinterface

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demultiplexer; each channel owns a 1-entry output register.
// Define STREAM_DEMUX_1TO4_CNT_EN to add per-channel drain counters cnt0..cnt3.
module stream_demux_1to4 #(
   parameter int W = 8
`ifdef STREAM_DEMUX_1TO4_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic               clk,
   input  logic               rst,
   stream_demux_1to4_if.slave bus
`ifdef STREAM_DEMUX_1TO4_CNT_EN
   , output logic [CNT_W-1:0] cnt0
   , output logic [CNT_W-1:0] cnt1
   , output logic [CNT_W-1:0] cnt2
   , output logic [CNT_W-1:0] cnt3
`endif
);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]   state  [4];
   logic [W-1:0] data_q [4];
   logic [3:0]   ready_v;
   logic [3:0]   drain;
   logic [3:0]   load;
   logic [1:0]   sel;
   logic         accept;

   assign sel     = {bus.S1, bus.S0};
   assign ready_v = {bus.y3_ready, bus.y2_ready, bus.y1_ready, bus.y0_ready};

   // A FULL channel can take a new word only when it is draining in the same cycle.
   assign bus.in_ready = (state[sel] == EMPTY) || ready_v[sel];
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
      drain = '0;
      load  = '0;
      for (int n = 0; n < 4; n++) begin
         drain[n] = (state[n] == FULL) && ready_v[n];
         load[n]  = accept && (sel == 2'(n));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the data registers are reset as well, because the channel data must read 0 while in reset.
         for (int n = 0; n < 4; n++) begin
            state[n]  <= EMPTY;
            data_q[n] <= '0;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
         for (int n = 0; n < 4; n++) begin
            if (load[n]) begin
               state[n]  <= FULL;
               data_q[n] <= bus.in_data;
            end else if (drain[n]) begin
               state[n] <= EMPTY;
            end
         end
      end
   end

   assign bus.y0_valid = (state[0] == FULL);
   assign bus.y1_valid = (state[1] == FULL);
   assign bus.y2_valid = (state[2] == FULL);
   assign bus.y3_valid = (state[3] == FULL);
   assign bus.y0       = data_q[0];
   assign bus.y1       = data_q[1];
   assign bus.y2       = data_q[2];
   assign bus.y3       = data_q[3];

`ifdef STREAM_DEMUX_1TO4_CNT_EN
   logic [CNT_W-1:0] cnt_q [4];

   // Counters wrap naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < 4; n++) cnt_q[n] <= '0;
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (drain[n]) cnt_q[n] <= cnt_q[n] + CNT_W'(1);
         end
      end
   end

   assign cnt0 = cnt_q[0];
   assign cnt1 = cnt_q[1];
   assign cnt2 = cnt_q[2];
   assign cnt3 = cnt_q[3];
`endif
endmodule

// File: tb/tb_stream_demux_1to4.sv
// Directed self-checking bench for stream_demux_1to4 (counter checks when STREAM_DEMUX_1TO4_CNT_EN is defined).
module tb_stream_demux_1to4;
   localparam int W = 8;

   logic clk;
   logic rst;
   int   pass_cnt;
   int   chk_cnt;
   int   cnt40;

   stream_demux_1to4_if #(.W(W)) bus ();

`ifdef STREAM_DEMUX_1TO4_CNT_EN
   localparam int CNT_W = 4;
   logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

   stream_demux_1to4 #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
   );
`else
   stream_demux_1to4 #(.W(W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts how many times word 8'h40 is handed off on y0.
   always @(posedge clk) begin
      if (bus.y0_valid && bus.y0_ready && bus.y0 == 8'h40) cnt40++;
   end

   function automatic logic [3:0] valids();
      return {bus.y3_valid, bus.y2_valid, bus.y1_valid, bus.y0_valid};
   endfunction

   task automatic drive(input logic v, input logic [W-1:0] d, input logic [1:0] s);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.S1       = s[1];
      bus.S0       = s[0];
   endtask

   task automatic set_ready(input logic [3:0] r);
      {bus.y3_ready, bus.y2_ready, bus.y1_ready, bus.y0_ready} = r;
   endtask

   task automatic test_reset();
      #3;
      chk_cnt++;
      if ({valids(), bus.y0, bus.y1, bus.y2, bus.y3} !== 36'h0)
         $display("FAIL reset_outputs: got valid=%b y=%h %h %h %h, expected all 0",
                  valids(), bus.y0, bus.y1, bus.y2, bus.y3);
      else pass_cnt++;
      chk_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      else pass_cnt++;
      @(negedge clk) rst = 1'b0;

      set_ready(4'b1011);
      drive(1'b1, 8'hA5, 2'b10);
      @(negedge clk);
      chk_cnt++;
      if ({bus.y2_valid, bus.y2} !== {1'b1, 8'hA5})
         $display("FAIL reset_load_y2: got valid=%b y2=%h expected 1 a5", bus.y2_valid, bus.y2);
      else pass_cnt++;
      drive(1'b0, 8'h00, 2'b00);
      #2 rst = 1'b1;
      #1;
      chk_cnt++;
      if ({valids(), bus.y0, bus.y1, bus.y2, bus.y3} !== 36'h0)
         $display("FAIL reset_async_clear: got valid=%b y2=%h expected 0 00", valids(), bus.y2);
      else pass_cnt++;
      chk_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_async_in_ready: got %b expected 1", bus.in_ready);
      else pass_cnt++;
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if ({valids(), bus.y2} !== 12'h000)
         $display("FAIL reset_no_stale: got valid=%b y2=%h expected 0 00", valids(), bus.y2);
      else pass_cnt++;
      set_ready(4'b1111);
   endtask

   task automatic test_routing();
      logic [W-1:0] words [4];
      logic [W-1:0] got;
      words = '{8'h10, 8'h11, 8'h12, 8'h13};
      set_ready(4'b1111);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i > 0) begin
            case (i - 1)
               0: got = bus.y0;
               1: got = bus.y1;
               2: got = bus.y2;
               default: got = bus.y3;
            endcase
            chk_cnt++;
            if ({valids(), got} !== {4'b0001 << (i - 1), words[i-1]})
               $display("FAIL routing_ch%0d: got valid=%b data=%h expected %b %h",
                        i - 1, valids(), got, 4'b0001 << (i - 1), words[i-1]);
            else pass_cnt++;
         end
         if (i < 4) begin
            drive(1'b1, words[i], 2'(i));
            #1;
            chk_cnt++;
            if (bus.in_ready !== 1'b1) $display("FAIL routing_in_ready%0d: got %b expected 1", i, bus.in_ready);
            else pass_cnt++;
         end else drive(1'b0, 8'h00, 2'b00);
      end
      @(negedge clk);
      chk_cnt++;
      if (valids() !== 4'b0000) $display("FAIL routing_idle: got valid=%b expected 0000", valids());
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      set_ready(4'b1101);
      @(negedge clk);
      drive(1'b1, 8'h21, 2'b01);
      @(negedge clk);
      chk_cnt++;
      if ({bus.y1_valid, bus.y1} !== {1'b1, 8'h21})
         $display("FAIL bp_y1_load: got %b %h expected 1 21", bus.y1_valid, bus.y1);
      else pass_cnt++;
      drive(1'b1, 8'h22, 2'b01);
      #1;
      chk_cnt++;
      if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b expected 0", bus.in_ready);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({bus.y1_valid, bus.y1, bus.in_ready} !== {1'b1, 8'h21, 1'b0})
         $display("FAIL bp_stall_hold: got %b %h in_ready=%b expected 1 21 0", bus.y1_valid, bus.y1, bus.in_ready);
      else pass_cnt++;
      drive(1'b1, 8'h30, 2'b00);
      #1;
      chk_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL bp_other_ready: got %b expected 1", bus.in_ready);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({valids(), bus.y0, bus.y1} !== {4'b0011, 8'h30, 8'h21})
         $display("FAIL bp_isolation: got valid=%b y0=%h y1=%h expected 0011 30 21", valids(), bus.y0, bus.y1);
      else pass_cnt++;
      drive(1'b0, 8'h00, 2'b00);
      set_ready(4'b1111);
      @(negedge clk);
      chk_cnt++;
      if (valids() !== 4'b0000) $display("FAIL bp_drain: got valid=%b expected 0000", valids());
      else pass_cnt++;
   endtask

   task automatic test_throughput();
      set_ready(4'b1111);
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk_cnt++;
            if ({bus.y3_valid, bus.y3} !== {1'b1, 8'(i - 1)})
               $display("FAIL thru_y3_%0d: got %b %h expected 1 %h", i - 1, bus.y3_valid, bus.y3, 8'(i - 1));
            else pass_cnt++;
         end
         if (i < 16) begin
            drive(1'b1, 8'(i), 2'b11);
            #1;
            chk_cnt++;
            if (bus.in_ready !== 1'b1) $display("FAIL thru_in_ready_%0d: got %b expected 1", i, bus.in_ready);
            else pass_cnt++;
         end else drive(1'b0, 8'h00, 2'b00);
      end
      @(negedge clk);
   endtask

   task automatic test_drain_fill();
      cnt40 = 0;
      set_ready(4'b1110);
      drive(1'b1, 8'h40, 2'b00);
      @(negedge clk);
      chk_cnt++;
      if ({bus.y0_valid, bus.y0} !== {1'b1, 8'h40})
         $display("FAIL df_y0_load: got %b %h expected 1 40", bus.y0_valid, bus.y0);
      else pass_cnt++;
      set_ready(4'b1111);
      drive(1'b1, 8'h41, 2'b00);
      #1;
      chk_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL df_in_ready: got %b expected 1", bus.in_ready);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({bus.y0_valid, bus.y0} !== {1'b1, 8'h41})
         $display("FAIL df_y0_overwrite: got %b %h expected 1 41", bus.y0_valid, bus.y0);
      else pass_cnt++;
      drive(1'b0, 8'h00, 2'b00);
      @(negedge clk);
      chk_cnt++;
      if (bus.y0_valid !== 1'b0) $display("FAIL df_y0_empty: got %b expected 0", bus.y0_valid);
      else pass_cnt++;
      chk_cnt++;
      if (cnt40 !== 1) $display("FAIL df_once: got %0d drains of 40 expected 1", cnt40);
      else pass_cnt++;
   endtask

`ifdef STREAM_DEMUX_1TO4_CNT_EN
   task automatic test_counter();
      @(negedge clk) rst = 1'b1;
      #1;
      chk_cnt++;
      if ({cnt0, cnt1, cnt2, cnt3} !== 16'h0)
         $display("FAIL cnt_reset: got %h %h %h %h expected 0", cnt0, cnt1, cnt2, cnt3);
      else pass_cnt++;
      @(negedge clk) rst = 1'b0;
      set_ready(4'b1111);
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 8'(8'h50 + i), 2'b10);
         @(negedge clk);
      end
      drive(1'b0, 8'h00, 2'b00);
      @(negedge clk);
      chk_cnt++;
      if (cnt2 !== 4'd1) $display("FAIL cnt2_wrap: got %0d expected 1", cnt2);
      else pass_cnt++;
      chk_cnt++;
      if ({cnt0, cnt1, cnt3} !== 12'h0)
         $display("FAIL cnt_others: got %0d %0d %0d expected 0 0 0", cnt0, cnt1, cnt3);
      else pass_cnt++;
   endtask
`endif

   initial begin
      pass_cnt = 0;
      chk_cnt  = 0;
      cnt40    = 0;
      rst      = 1'b1;
      drive(1'b0, 8'h00, 2'b00);
      set_ready(4'b1111);
      test_reset();
      test_routing();
      test_backpressure();
      test_throughput();
      test_drain_fill();
`ifdef STREAM_DEMUX_1TO4_CNT_EN
      test_counter();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
